// File: rtl/pipe_ctrl.sv
// Pipeline control for the RV32I five-stage core: load-use stalls, jump flushes,
// halt/drain handshake and saturating stall/flush event counters.
module pipe_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_reg_wen_i,
    input  logic             ex_is_load_i,
    input  logic             jump_en_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             halt_req_i,
    output logic             halt_ack_o,
    output logic             jump_en_o,
    output logic [31:0]      jump_addr_o,
    output logic             pc_hold_o,
    output logic             if_id_hold_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int DW = $clog2(DRAIN_CYCLES) + 1;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic             halt_ack_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             lu;
    logic             stall_inc, flush_inc;

    assign lu = ex_is_load_i & ex_reg_wen_i & (ex_rd_addr_i != 5'd0) &
                ((ex_rd_addr_i == id_rs1_addr_i) | (ex_rd_addr_i == id_rs2_addr_i));

    always_comb begin
        state_d       = state_q;
        dcnt_d        = dcnt_q;
        jump_en_o     = 1'b0;
        jump_addr_o   = 32'd0;
        pc_hold_o     = 1'b0;
        if_id_hold_o  = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;

        case (state_q)
            RUN: begin
                if (jump_en_i) begin
                    flush_inc = 1'b1;
                end else if (lu) begin
                    pc_hold_o     = 1'b1;
                    if_id_hold_o  = 1'b1;
                    id_ex_flush_o = 1'b1;
                    stall_inc     = 1'b1;
                end else if (halt_req_i) begin
                    pc_hold_o     = 1'b1;
                    if_id_flush_o = 1'b1;
                    state_d       = DRAIN;
                    dcnt_d        = DW'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                pc_hold_o     = 1'b1;
                if_id_flush_o = 1'b1;
                flush_inc     = jump_en_i;
                if (!halt_req_i) begin
                    state_d = RUN;
                    dcnt_d  = '0;
                end else if (dcnt_q == '0) begin
                    state_d = HALTED;
                end else begin
                    dcnt_d = dcnt_q - DW'(1);
                end
            end
            HALTED: begin
                pc_hold_o     = 1'b1;
                if_id_flush_o = 1'b1;
                flush_inc     = jump_en_i;
                if (!halt_req_i) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                dcnt_d  = '0;
            end
        endcase

        // A resolved jump wins over every hold in every state.
        if (jump_en_i) begin
            jump_en_o     = 1'b1;
            jump_addr_o   = jump_addr_i;
            pc_hold_o     = 1'b0;
            if_id_hold_o  = 1'b0;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            dcnt_q      <= '0;
            halt_ack_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            dcnt_q     <= dcnt_d;
            halt_ack_q <= (state_d == HALTED);
            if (stall_inc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign halt_ack_o  = halt_ack_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a vector table for the RUN-state combinational
// behaviour, then hand-written halt, drain-jump, abort, reset and saturation sequences.
module tb_pipe_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  rs1Addr, rs2Addr, rdAddr;
    logic        regWen, isLoad, jumpEnIn, haltReq;
    logic [31:0] jumpAddrIn;

    logic        haltAck, jumpEnOut, pcHold, ifIdHold, ifIdFlush, idExFlush;
    logic [31:0] jumpAddrOut, stallCnt, flushCnt;

    logic        satHaltAck, satJumpEn, satPcHold, satIfIdHold, satIfIdFlush, satIdExFlush;
    logic [31:0] satJumpAddr;
    logic [3:0]  satStallCnt, satFlushCnt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipe_ctrl #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
        .clk(clock), .rst(reset),
        .id_rs1_addr_i(rs1Addr), .id_rs2_addr_i(rs2Addr), .ex_rd_addr_i(rdAddr),
        .ex_reg_wen_i(regWen), .ex_is_load_i(isLoad),
        .jump_en_i(jumpEnIn), .jump_addr_i(jumpAddrIn), .halt_req_i(haltReq),
        .halt_ack_o(haltAck), .jump_en_o(jumpEnOut), .jump_addr_o(jumpAddrOut),
        .pc_hold_o(pcHold), .if_id_hold_o(ifIdHold), .if_id_flush_o(ifIdFlush),
        .id_ex_flush_o(idExFlush), .stall_cnt_o(stallCnt), .flush_cnt_o(flushCnt)
    );

    pipe_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) dutSat (
        .clk(clock), .rst(reset),
        .id_rs1_addr_i(rs1Addr), .id_rs2_addr_i(rs2Addr), .ex_rd_addr_i(rdAddr),
        .ex_reg_wen_i(regWen), .ex_is_load_i(isLoad),
        .jump_en_i(jumpEnIn), .jump_addr_i(jumpAddrIn), .halt_req_i(haltReq),
        .halt_ack_o(satHaltAck), .jump_en_o(satJumpEn), .jump_addr_o(satJumpAddr),
        .pc_hold_o(satPcHold), .if_id_hold_o(satIfIdHold), .if_id_flush_o(satIfIdFlush),
        .id_ex_flush_o(satIdExFlush), .stall_cnt_o(satStallCnt), .flush_cnt_o(satFlushCnt)
    );

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wen;
        logic        load;
        logic        jen;
        logic [31:0] jaddr;
        logic        halt;
        logic        expJen;
        logic [31:0] expJaddr;
        logic        expPcHold;
        logic        expIfIdHold;
        logic        expIfIdFlush;
        logic        expIdExFlush;
        int          expStall;
        int          expFlush;
    } vec_t;

    vec_t vecs[13];

    // Drive every DUT input at once; called just after a rising edge.
    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic wen, input logic load,
                                 input logic jen, input logic [31:0] jaddr, input logic halt);
        rs1Addr    = rs1;
        rs2Addr    = rs2;
        rdAddr     = rd;
        regWen     = wen;
        isLoad     = load;
        jumpEnIn   = jen;
        jumpAddrIn = jaddr;
        haltReq    = halt;
    endtask

    // One comparison: counts it and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkControls(input string tag, input logic expJen, input logic [31:0] expJaddr,
                                 input logic expPch, input logic expIfh, input logic expIff,
                                 input logic expIef);
        checkOutput({tag, " jump_en"},     {31'd0, jumpEnOut}, {31'd0, expJen});
        checkOutput({tag, " jump_addr"},   jumpAddrOut,        expJaddr);
        checkOutput({tag, " pc_hold"},     {31'd0, pcHold},    {31'd0, expPch});
        checkOutput({tag, " if_id_hold"},  {31'd0, ifIdHold},  {31'd0, expIfh});
        checkOutput({tag, " if_id_flush"}, {31'd0, ifIdFlush}, {31'd0, expIff});
        checkOutput({tag, " id_ex_flush"}, {31'd0, idExFlush}, {31'd0, expIef});
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic doReset();
        @(negedge clock);
        #1 reset = 1'b1;
        idle();
        #2 reset = 1'b0;
        nextCycle();
    endtask

    initial begin
        //              rs1   rs2   rd    wen  ld   jen  jaddr         halt | jen  jaddr         pch  ifh  iff  ief  st fl
        vecs[0]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        vecs[1]  = '{5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 0, 0};
        vecs[2]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1, 0};
        vecs[3]  = '{5'd7, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1, 0};
        vecs[4]  = '{5'd7, 5'd2, 5'd7, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 2, 0};
        vecs[5]  = '{5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 2, 0};
        vecs[6]  = '{5'd3, 5'd4, 5'd7, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 2, 0};
        vecs[7]  = '{5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 32'h100,      1'b0, 1'b1, 32'h100,      1'b0, 1'b0, 1'b1, 1'b1, 2, 0};
        vecs[8]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'hdeadbeef, 1'b0, 1'b1, 32'hdeadbeef, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1};
        vecs[9]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h1234,     1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 2, 2};
        vecs[10] = '{5'd9, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 2, 2};
        vecs[11] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h40,       1'b1, 1'b1, 32'h40,       1'b0, 1'b0, 1'b1, 1'b1, 3, 2};
        vecs[12] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 3, 3};

        reset = 1'b1;
        idle();
        #2;
        checkControls("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset halt_ack", {31'd0, haltAck}, 32'd0);
        checkOutput("reset stall_cnt", stallCnt, 32'd0);
        checkOutput("reset flush_cnt", flushCnt, 32'd0);
        #10 reset = 1'b0;
        nextCycle();

        // Single-cycle RUN behaviour from the vector table.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].wen, vecs[i].load,
                          vecs[i].jen, vecs[i].jaddr, vecs[i].halt);
            @(negedge clock);
            checkControls($sformatf("vec%0d", i), vecs[i].expJen, vecs[i].expJaddr,
                          vecs[i].expPcHold, vecs[i].expIfIdHold, vecs[i].expIfIdFlush,
                          vecs[i].expIdExFlush);
            checkOutput($sformatf("vec%0d stall_cnt", i), stallCnt, 32'(vecs[i].expStall));
            checkOutput($sformatf("vec%0d flush_cnt", i), flushCnt, 32'(vecs[i].expFlush));
            checkOutput($sformatf("vec%0d halt_ack", i), {31'd0, haltAck}, 32'd0);
            nextCycle();
        end
        checkOutput("table stall_cnt", stallCnt, 32'd3);
        checkOutput("table flush_cnt", flushCnt, 32'd3);

        // Full halt: request in cycle 0, ack from cycle 4, release at cycle 6.
        for (int c = 0; c < 8; c++) begin
            applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, (c < 6));
            @(negedge clock);
            checkOutput($sformatf("halt c%0d ack", c), {31'd0, haltAck}, {31'd0, (c >= 4 && c <= 6)});
            checkOutput($sformatf("halt c%0d pc_hold", c), {31'd0, pcHold}, {31'd0, (c <= 6)});
            checkOutput($sformatf("halt c%0d if_id_flush", c), {31'd0, ifIdFlush}, {31'd0, (c <= 6)});
            nextCycle();
        end

        // Jump taken in the second drain cycle: redirect, then hold again; ack timing unchanged.
        for (int c = 0; c < 7; c++) begin
            applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, (c == 2), (c == 2) ? 32'h200 : 32'h0, (c < 5));
            @(negedge clock);
            if (c == 2) begin
                checkControls("drainjump c2", 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1);
            end else begin
                checkOutput($sformatf("drainjump c%0d pc_hold", c), {31'd0, pcHold}, {31'd0, (c <= 5)});
                checkOutput($sformatf("drainjump c%0d jump_en", c), {31'd0, jumpEnOut}, 32'd0);
            end
            checkOutput($sformatf("drainjump c%0d ack", c), {31'd0, haltAck}, {31'd0, (c == 4 || c == 5)});
            nextCycle();
        end
        checkOutput("drainjump flush_cnt", flushCnt, 32'd4);

        // Abort: request dropped in drain cycle 2, RUN from cycle 3, never acked.
        for (int c = 0; c < 7; c++) begin
            applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, (c < 2));
            @(negedge clock);
            checkOutput($sformatf("abort c%0d pc_hold", c), {31'd0, pcHold}, {31'd0, (c <= 2)});
            checkOutput($sformatf("abort c%0d ack", c), {31'd0, haltAck}, 32'd0);
            nextCycle();
        end

        // Asynchronous reset while halted with non-zero counters.
        for (int c = 0; c < 5; c++) begin
            applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
            nextCycle();
        end
        @(negedge clock);
        checkOutput("prereset halt_ack", {31'd0, haltAck}, 32'd1);
        #1;
        haltReq = 1'b0;
        reset   = 1'b1;
        #1;
        checkOutput("asyncrst halt_ack", {31'd0, haltAck}, 32'd0);
        checkOutput("asyncrst stall_cnt", stallCnt, 32'd0);
        checkOutput("asyncrst flush_cnt", flushCnt, 32'd0);
        checkOutput("asyncrst pc_hold", {31'd0, pcHold}, 32'd0);
        checkOutput("asyncrst if_id_flush", {31'd0, ifIdFlush}, 32'd0);
        #1 reset = 1'b0;
        nextCycle();
        applyStimulus(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        @(negedge clock);
        checkControls("postrst lu", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        nextCycle();
        idle();
        @(negedge clock);
        checkOutput("postrst stall_cnt", stallCnt, 32'd1);
        checkControls("postrst idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();

        // 17 back-to-back load-use cycles: 4-bit counter stops at 15, 32-bit reaches 17.
        doReset();
        for (int c = 0; c < 17; c++) begin
            applyStimulus(5'd0, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
            nextCycle();
            if (c == 14) begin
                checkOutput("sat after15", {28'd0, satStallCnt}, 32'd15);
            end
        end
        idle();
        @(negedge clock);
        checkOutput("sat stall_cnt", {28'd0, satStallCnt}, 32'd15);
        checkOutput("sat flush_cnt", {28'd0, satFlushCnt}, 32'd0);
        checkOutput("wide stall_cnt", stallCnt, 32'd17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
